// File: rtl/uv_iomux_pkg.sv
// Shared definitions for the IO mux pin-function controller.
// Register word offsets (addr[3:2]), group bit positions and FSM encoding.
package uv_iomux_pkg;

  localparam logic [1:0] REG_MODE_REQ = 2'd0;
  localparam logic [1:0] REG_MODE_CUR = 2'd1;
  localparam logic [1:0] REG_STATUS   = 2'd2;
  localparam logic [1:0] REG_GUARD    = 2'd3;

  localparam int GRP_UART = 0;
  localparam int GRP_SPI0 = 1;
  localparam int GRP_SPI1 = 2;

  localparam int GUARD_RST = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD,
    ST_SETTLE
  } state_e;

endpackage

// File: rtl/uv_iomux_ctrl_if.sv
// System register bus: one-cycle request strobe, response exactly one cycle later.
// No backpressure; the slave always accepts.
interface uv_iomux_ctrl_if;
  logic        reg_req;
  logic        reg_we;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_rsp;
  logic [31:0] reg_rdata;

  modport master (
    output reg_req, reg_we, reg_addr, reg_wdata,
    input  reg_rsp, reg_rdata
  );

  modport slave (
    input  reg_req, reg_we, reg_addr, reg_wdata,
    output reg_rsp, reg_rdata
  );
endinterface

// File: rtl/uv_iomux_ctrl.sv
// Sequences glitch-free pin-function changes: wait idle, hold for GUARD+1, switch, settle.
// Register response one cycle after request, never stalls; switch latency depends on grp_idle.
module uv_iomux_ctrl
  import uv_iomux_pkg::*;
#(
  parameter int                   GRP_NUM  = 3,
  parameter logic [GRP_NUM-1:0]   RST_MODE = '1,
  parameter int                   GRD_W    = 8,
  parameter int                   TMO_CYC  = 4096
) (
  input  logic               clk,
  input  logic               rst,
  uv_iomux_ctrl_if.slave     bus,
  input  logic [GRP_NUM-1:0] grp_idle,
  output logic [GRP_NUM-1:0] mode_cur,
  output logic [GRP_NUM-1:0] pin_hold,
  output logic               busy,
  output logic               done_irq
);

  localparam int CNT_W = (GRD_W > $clog2(TMO_CYC)) ? GRD_W : $clog2(TMO_CYC);

  state_e             state_q, state_d;
  logic [GRP_NUM-1:0] mode_req_q;
  logic [GRP_NUM-1:0] mode_cur_q, mode_cur_d;
  logic [GRP_NUM-1:0] tgt_q, tgt_d;
  logic [GRP_NUM-1:0] chg_q, chg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GRD_W-1:0]   guard_q;
  logic               tmo_err_q, tmo_set;
  logic               done_q, rsp_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               idle_ok, wr;
  logic               unused_bits;

  assign idle_ok = &(grp_idle | ~chg_q);
  assign wr      = bus.reg_req & bus.reg_we;

  // One counter serves both the idle timeout (counting up) and the guard window (counting down)
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    chg_d      = chg_q;
    mode_cur_d = mode_cur_q;
    tmo_set    = 1'b0;
    busy       = (state_q != ST_IDLE);
    pin_hold   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (mode_req_q != mode_cur_q) begin
          tgt_d   = mode_req_q;
          chg_d   = mode_req_q ^ mode_cur_q;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (idle_ok) begin
          cnt_d   = CNT_W'(guard_q);
          state_d = ST_HOLD;
        end else if (cnt_q == CNT_W'(TMO_CYC - 1)) begin
          tmo_set = 1'b1;
          cnt_d   = CNT_W'(guard_q);
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        pin_hold = chg_q;
        if (cnt_q == '0) begin
          mode_cur_d = tgt_q;
          state_d    = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        pin_hold = chg_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    if (bus.reg_req && !bus.reg_we) begin
      unique case (bus.reg_addr[3:2])
        REG_MODE_REQ: rdata_d = {{(32-GRP_NUM){1'b0}}, mode_req_q};
        REG_MODE_CUR: rdata_d = {{(32-GRP_NUM){1'b0}}, mode_cur_q};
        REG_STATUS:   rdata_d = {30'd0, tmo_err_q, busy};
        REG_GUARD:    rdata_d = {{(32-GRD_W){1'b0}}, guard_q};
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_req_q <= RST_MODE;
      mode_cur_q <= RST_MODE;
      tgt_q      <= RST_MODE;
      chg_q      <= '0;
      cnt_q      <= '0;
      guard_q    <= GRD_W'(GUARD_RST);
      tmo_err_q  <= 1'b0;
      done_q     <= 1'b0;
      rsp_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      mode_cur_q <= mode_cur_d;
      tgt_q      <= tgt_d;
      chg_q      <= chg_d;
      cnt_q      <= cnt_d;
      done_q     <= (state_q == ST_SETTLE);
      rsp_q      <= bus.reg_req;
      rdata_q    <= rdata_d;
      if (wr && bus.reg_addr[3:2] == REG_MODE_REQ) mode_req_q <= bus.reg_wdata[GRP_NUM-1:0];
      if (wr && bus.reg_addr[3:2] == REG_GUARD)    guard_q    <= bus.reg_wdata[GRD_W-1:0];
      // A timeout landing in the same cycle as a clear keeps the error visible
      if (tmo_set)
        tmo_err_q <= 1'b1;
      else if (wr && bus.reg_addr[3:2] == REG_STATUS && bus.reg_wdata[1])
        tmo_err_q <= 1'b0;
    end
  end

  assign mode_cur      = mode_cur_q;
  assign done_irq      = done_q;
  assign bus.reg_rsp   = rsp_q;
  assign bus.reg_rdata = rdata_q;
  assign unused_bits   = ^{bus.reg_addr[1:0], bus.reg_wdata};

endmodule
